// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//   Boot loader fed by the UART byte receiver. It parses the frame
//     0xA5, LEN_LO, LEN_HI, N x {b0,b1,b2,b3} (little-endian words) [, CHK]
//   and writes each assembled word into instruction memory starting at
//   BASE_ADDR. Addresses wrap modulo 2^ADDR_W. The CPU is held while a
//   frame is in flight.
//
//   Optional feature macro: UART_LOADER_CHECKSUM_EN
//     defined   : a trailing checksum byte (8-bit sum of the data bytes) is
//                 expected; a mismatch raises load_err and suppresses load_done.
//     undefined : the frame ends right after the last data word.
//
// Ports
//   clk, rst_n         : clock, synchronous active-low reset
//   rx_data, rx_valid  : byte stream from the UART receiver (1-cycle strobe)
//   mem_we             : 1-cycle word write strobe
//   mem_addr, mem_wdata: write address / data, valid while mem_we is high
//   cpu_hold, busy     : high while a frame is being received
//   load_done          : 1-cycle pulse on a successful frame
//   load_err           : sticky error, cleared by the next accepted sync byte
module uart_imem_loader #(
  parameter int ADDR_W         = 10,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [7:0]        SYNC     = 8'hA5;
  localparam logic [31:0]       MAX_LEN  = 32'(1) << ADDR_W;
  localparam logic [31:0]       TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
`ifdef UART_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DATA
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic [15:0] len_full;
  assign len_full = {rx_data, len_lo_q};

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef UART_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    // Inter-byte gap counter: idle in IDLE, reloaded by every byte.
    if (state_q == S_IDLE || rx_valid) tmo_d = '0;
    else                               tmo_d = tmo_q + 32'd1;

    if (rx_valid) begin
      // A byte arriving on the expiry cycle wins over the timeout.
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC) begin
            state_d = S_LEN_LO;
            err_d   = 1'b0;
            idx_d   = '0;
            bcnt_d  = '0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end
        end
        S_LEN_LO: begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d = len_full;
          if ({16'd0, len_full} > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (len_full == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            done_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d  = sum_q + rx_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          // Shift right so the first byte of the word ends up in bits [7:0].
          asm_d  = {rx_data, asm_q[23:8]};
          if (bcnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_A + ADDR_W'(idx_q);
            mem_wdata_d = {rx_data, asm_q};
            idx_d       = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              done_d  = 1'b1;
              state_d = S_IDLE;
`endif
            end
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (rx_data == sum_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end

    // Registered from the next state so busy drops with load_done / load_err.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      asm_q       <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      asm_q       <= asm_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign cpu_hold  = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader. Two instances share one byte stream:
//   d0: ADDR_W=10, BASE_ADDR=0  (never over capacity for the frames used)
//   d1: ADDR_W=2,  BASE_ADDR=3  (capacity 4 words, addresses wrap)
// Expected writes / done / err come from frame-level rules, not from
// tracking parser state.
module tb_uart_imem_loader;

  localparam int T = 100;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;

  logic        we0, hold0, busy0, done0, err0;
  logic [9:0]  addr0;
  logic [31:0] wd0;
  logic        we1, hold1, busy1, done1, err1;
  logic [1:0]  addr1;
  logic [31:0] wd1;

  always #5 clk = ~clk;

  uart_imem_loader #(.ADDR_W(10), .BASE_ADDR(0), .TIMEOUT_CYCLES(T)) u_d0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0), .cpu_hold(hold0),
    .busy(busy0), .load_done(done0), .load_err(err0));

  uart_imem_loader #(.ADDR_W(2), .BASE_ADDR(3), .TIMEOUT_CYCLES(T)) u_d1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1), .cpu_hold(hold1),
    .busy(busy1), .load_done(done1), .load_err(err1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Observed writes and done pulses per instance.
  int          a_q[2][$];
  int unsigned w_q[2][$];
  int          dn[2];

  always @(negedge clk) begin
    if (we0) begin a_q[0].push_back(int'(addr0)); w_q[0].push_back(wd0); end
    if (we1) begin a_q[1].push_back(int'(addr1)); w_q[1].push_back(wd1); end
    if (done0) dn[0]++;
    if (done1) dn[1]++;
    // cpu_hold must mirror busy at all times
    if (hold0 !== busy0 || hold1 !== busy1) check_eq("hold_eq_busy", 64'({hold0, hold1}), 64'({busy0, busy1}));
  end

  int unsigned wq[$];     // words of the current frame
  logic [7:0]  garb[$];   // junk bytes before the sync byte

  task automatic clear_obs();
    for (int d = 0; d < 2; d++) begin
      a_q[d].delete();
      w_q[d].delete();
      dn[d] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one byte for exactly one cycle; returns 1 time unit after the
  // edge that sampled it, so registered responses are visible immediately.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] word_byte(input int unsigned w, input int k);
    logic [31:0] t;
    t = w;
    return t[8*k +: 8];
  endfunction

  function automatic logic [7:0] frame_sum();
    logic [7:0] s;
    s = 8'd0;
    foreach (wq[i]) for (int k = 0; k < 4; k++) s += word_byte(wq[i], k);
    return s;
  endfunction

  // Random words with no 0xA5 byte, and a checksum (good or good+1) that is
  // not 0xA5, so an instance sitting in IDLE never resyncs on frame content.
  task automatic gen_words(input int len);
    logic [7:0] s;
    logic [7:0] b;
    logic [31:0] w;
    do begin
      wq.delete();
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < 4; k++) begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hA5) b = 8'h5A;
          w[8*k +: 8] = b;
        end
        wq.push_back(w);
      end
      s = frame_sum();
    end while (s == 8'hA5 || s == 8'hA4);
  endtask

  task automatic verify(input int d, input int aw, input int base, input int trunc,
                        input bit good, input logic errv, input logic busyv);
    int len, cap, nexp, nchk;
    bit over;
    logic exp_done, exp_err;
    len  = wq.size();
    cap  = 1 << aw;
    over = (len > cap);
    nexp = over ? 0 : ((trunc < 0) ? len : trunc / 4);
    exp_done = (!over && trunc < 0) ? (CHK_EN ? good : 1'b1) : 1'b0;
    exp_err  = over || (trunc >= 0) || (CHK_EN && !good);
    check_eq($sformatf("d%0d_nwrites", d), 64'(a_q[d].size()), 64'(nexp));
    nchk = (a_q[d].size() < nexp) ? a_q[d].size() : nexp;
    for (int i = 0; i < nchk; i++) begin
      check_eq($sformatf("d%0d_addr%0d", d, i), 64'(a_q[d][i]), 64'((base + i) % cap));
      check_eq($sformatf("d%0d_data%0d", d, i), 64'(w_q[d][i]), 64'(wq[i]));
    end
    check_eq($sformatf("d%0d_ndone", d), 64'(dn[d]), 64'(exp_done));
    check_eq($sformatf("d%0d_err", d), 64'(errv), 64'(exp_err));
    check_eq($sformatf("d%0d_busy_end", d), 64'(busyv), 64'(0));
  endtask

  // trunc < 0: complete frame; otherwise only 'trunc' data bytes, then silence.
  task automatic run_frame(input bit good, input int trunc, input int gap);
    logic [7:0] s;
    int len, nb;
    logic exp_done0;
    len = wq.size();
    s   = frame_sum();
    exp_done0 = CHK_EN ? good : 1'b1;
    clear_obs();
    foreach (garb[i]) begin send(garb[i]); idle($urandom_range(0, gap)); end
    send(8'hA5);
    check_eq("sync_busy", 64'({busy0, busy1}), 64'(2'b11));
    check_eq("sync_err_clr", 64'({err0, err1}), 64'(2'b00));
    idle($urandom_range(0, gap));
    send(8'(len));
    idle($urandom_range(0, gap));
    send(8'(len >> 8));
    check_eq("d1_len_over_err", 64'(err1), 64'(len > 4));
    nb = (trunc < 0) ? 4 * len : trunc;
    for (int j = 0; j < nb; j++) begin
      idle($urandom_range(0, gap));
      send(word_byte(wq[j / 4], j % 4));
      if (j % 4 == 3) begin
        check_eq("d0_we", 64'(we0), 64'(1));
        check_eq("d0_we_addr", 64'(addr0), 64'(j / 4));
        check_eq("d0_we_data", 64'(wd0), 64'(wq[j / 4]));
      end
    end
    if (trunc < 0) begin
      if (CHK_EN) begin
        idle($urandom_range(0, gap));
        send(good ? s : s + 8'd1);
      end
      check_eq("d0_done_at_end", 64'(done0), 64'(exp_done0));
      check_eq("d0_busy_at_end", 64'(busy0), 64'(0));
      idle(4);
    end else begin
      idle(T - 1);
      check_eq("tmo_not_yet", 64'({err0, busy0}), 64'(2'b01));
      idle(1);
      check_eq("tmo_err_hold", 64'({err0, busy0, hold0}), 64'(3'b100));
      idle(3);
    end
    verify(0, 10, 0, trunc, good, err0, busy0);
    verify(1, 2, 3, trunc, good, err1, busy1);
  endtask

  initial begin
    int len, trunc;
    bit good;
    logic [7:0] b;

    // Reset state
    idle(3);
    check_eq("rst_d0", 64'({we0, addr0, wd0, hold0, busy0, done0, err0}), 64'(0));
    check_eq("rst_d1", 64'({we1, addr1, wd1, hold1, busy1, done1, err1}), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Known two-word frame, good then bad checksum, back-to-back bytes
    garb.delete();
    wq = '{32'h12345678, 32'hDEADBEEF};
    run_frame(1'b1, -1, 0);
    run_frame(1'b0, -1, 0);

    // Leading junk ignored, single word
    garb = '{8'h00, 8'hFF, 8'h13};
    wq = '{32'h01020304};
    run_frame(1'b1, -1, 1);
    garb.delete();

    // Timeout after 5 of 12 data bytes
    gen_words(3);
    run_frame(1'b1, 5, 0);

    // Length over d1 capacity; two words at d1 wrap 3 -> 0
    gen_words(5);
    run_frame(1'b1, -1, 1);
    gen_words(2);
    run_frame(1'b1, -1, 0);
    gen_words(0);
    run_frame(1'b1, -1, 0);

    // Reset in the middle of DATA
    gen_words(2);
    clear_obs();
    send(8'hA5); send(8'h02); send(8'h00);
    send(word_byte(wq[0], 0)); send(word_byte(wq[0], 1));
    rst_n = 1'b0;
    idle(1);
    check_eq("midrst_d0", 64'({we0, addr0, wd0, hold0, busy0, done0, err0}), 64'(0));
    check_eq("midrst_d1", 64'({we1, addr1, wd1, hold1, busy1, done1, err1}), 64'(0));
    rst_n = 1'b1;
    for (int j = 2; j < 8; j++) send(word_byte(wq[j / 4], j % 4));
    send(frame_sum());
    idle(T + 5);
    check_eq("midrst_nwr", 64'(a_q[0].size() + a_q[1].size()), 64'(0));
    check_eq("midrst_done", 64'(dn[0] + dn[1]), 64'(0));
    check_eq("midrst_state", 64'({busy0, err0, busy1, err1}), 64'(0));
    gen_words(2);
    run_frame(1'b1, -1, 0);

    // Randomized frames
    for (int n = 0; n < 25; n++) begin
      garb.delete();
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        garb.push_back(b);
      end
      len  = $urandom_range(0, 6);
      good = 1'($urandom_range(0, 1));
      trunc = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, 4 * len - 1) : -1;
      gen_words(len);
      run_frame(good, trunc, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
